// File: rtl/alu.sv
// Registered arithmetic/logic unit for the calculator execute stage.
// One-cycle latency: operands qualified by in_valid are computed and every
// output registers on the same rising edge; out_valid pulses the next cycle.
// Build option: define ALU_EXT_OPS_EN to enable XOR/SHL/SHR on opcodes
// 101/110/111. Without it those opcodes report illegal with a zero result.
module alu #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       opcode,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic             carry,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
`ifdef ALU_EXT_OPS_EN
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;
`endif

    logic [WIDTH-1:0] result_q, result_d;
    logic             valid_q;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             overflow_q, overflow_d;
    logic             illegal_q, illegal_d;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
`ifdef ALU_EXT_OPS_EN
    // Extra bit catches the last bit shifted out (MSB side for SHL, LSB for SHR).
    logic [WIDTH:0]   shl_ext;
    logic [WIDTH:0]   shr_ext;
`endif

    // Next-value computation for result and flags of the presented operation.
    always_comb begin
        result_d   = '0;
        carry_d    = 1'b0;
        overflow_d = 1'b0;
        illegal_d  = 1'b0;
        sum        = {1'b0, A} + {1'b0, B};
        diff       = {1'b0, A} - {1'b0, B};
`ifdef ALU_EXT_OPS_EN
        shl_ext    = {1'b0, A} << B[1:0];
        shr_ext    = {A, 1'b0} >> B[1:0];
`endif
        case (opcode)
            OP_ADD: begin
                result_d   = sum[WIDTH-1:0];
                carry_d    = sum[WIDTH];
                overflow_d = (A[WIDTH-1] == B[WIDTH-1]) &&
                             (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                // Borrow shows up as the extended MSB of the unsigned difference.
                result_d   = diff[WIDTH-1:0];
                carry_d    = diff[WIDTH];
                overflow_d = (A[WIDTH-1] != B[WIDTH-1]) &&
                             (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND: result_d = A & B;
            OP_OR:  result_d = A | B;
            OP_NOT: result_d = ~A;
`ifdef ALU_EXT_OPS_EN
            OP_XOR: result_d = A ^ B;
            OP_SHL: begin
                result_d = shl_ext[WIDTH-1:0];
                carry_d  = shl_ext[WIDTH];
            end
            OP_SHR: begin
                result_d = shr_ext[WIDTH:1];
                carry_d  = shr_ext[0];
            end
            default: result_d = '0;
`else
            default: illegal_d = 1'b1;
`endif
        endcase
        zero_d = (result_d == '0);
    end

    // Output registers: load on accepted operations, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q   <= '0;
            valid_q    <= 1'b0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                result_q   <= result_d;
                carry_q    <= carry_d;
                zero_q     <= zero_d;
                overflow_q <= overflow_d;
                illegal_q  <= illegal_d;
            end
        end
    end

    assign result    = result_q;
    assign out_valid = valid_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign overflow  = overflow_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu.sv
// Directed bench for the 4-bit alu: hand-computed vectors for every opcode,
// arithmetic boundaries, back-to-back issue, idle hold and async reset.
module tb_alu;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       opcode;
    logic [WIDTH-1:0] result;
    logic             out_valid;
    logic             carry;
    logic             zero;
    logic             overflow;
    logic             illegal;

    int n_cmp = 0;
    int n_err = 0;

    alu #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .opcode    (opcode),
        .result    (result),
        .out_valid (out_valid),
        .carry     (carry),
        .zero      (zero),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Check every output at once; expected fields in order result,valid,c,z,ov,il.
    task automatic chk_all(input string tag, input logic [WIDTH-1:0] r, input logic v,
                           input logic c, input logic z, input logic ov, input logic il);
        chk({tag, ".result"},   {28'd0, result},    {28'd0, r});
        chk({tag, ".valid"},    {31'd0, out_valid}, {31'd0, v});
        chk({tag, ".carry"},    {31'd0, carry},     {31'd0, c});
        chk({tag, ".zero"},     {31'd0, zero},      {31'd0, z});
        chk({tag, ".overflow"}, {31'd0, overflow},  {31'd0, ov});
        chk({tag, ".illegal"},  {31'd0, illegal},   {31'd0, il});
    endtask

    task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] op);
        @(negedge clk);
        A        = a;
        B        = b;
        opcode   = op;
        in_valid = 1'b1;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        A        = '0;
        B        = '0;
        opcode   = 3'b000;

        // Reset held 100 ns, released with nothing valid.
        #100;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            after_edge();
            chk_all("post_reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // ADD 3+5: signed 3+5 overflows 4 bits.
        drive(4'd3, 4'd5, 3'b000);
        after_edge();
        chk_all("add_3_5", 4'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        // SUB 10-3: -6-3 signed overflows too.
        drive(4'd10, 4'd3, 3'b001);
        after_edge();
        chk_all("sub_10_3", 4'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // Idle: outputs hold, no valid.
        idle();
        after_edge();
        chk_all("idle_hold", 4'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Back-to-back AND / OR / NOT.
        drive(4'd12, 4'd6, 3'b010);
        after_edge();
        chk_all("and_12_6", 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(4'd9, 4'd5, 3'b011);
        after_edge();
        chk_all("or_9_5", 4'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(4'd9, 4'd7, 3'b100);
        after_edge();
        chk_all("not_9", 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        after_edge();
        chk("b2b_valid_drop", {31'd0, out_valid}, 32'd0);

        // Arithmetic boundaries.
        drive(4'd15, 4'd1, 3'b000);
        after_edge();
        chk_all("add_15_1", 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(4'd3, 4'd5, 3'b001);
        after_edge();
        chk_all("sub_3_5", 4'd14, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(4'd8, 4'd1, 3'b001);
        after_edge();
        chk_all("sub_8_1", 4'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(4'd6, 4'd6, 3'b001);
        after_edge();
        chk_all("sub_6_6", 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Extended opcode space.
`ifdef ALU_EXT_OPS_EN
        drive(4'd9, 4'd5, 3'b101);
        after_edge();
        chk_all("xor_9_5", 4'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(4'd5, 4'd2, 3'b110);
        after_edge();
        chk_all("shl_5_2", 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(4'd6, 4'd2, 3'b111);
        after_edge();
        chk_all("shr_6_2", 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(4'd6, 4'd0, 3'b111);
        after_edge();
        chk_all("shr_6_0", 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`else
        drive(4'd9, 4'd5, 3'b101);
        after_edge();
        chk_all("op101", 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        drive(4'd5, 4'd2, 3'b110);
        after_edge();
        chk_all("op110", 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        drive(4'd6, 4'd2, 3'b111);
        after_edge();
        chk_all("op111", 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
`endif
        // A legal op right after clears illegal.
        drive(4'd1, 4'd1, 3'b000);
        after_edge();
        chk_all("add_1_1", 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Async reset mid-stream: next op is presented, reset lands between edges.
        drive(4'd2, 4'd3, 3'b000);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_clear", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        after_edge();
        chk_all("reset_held", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        after_edge();
        chk_all("after_reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Operation still works after recovery.
        drive(4'd4, 4'd2, 3'b001);
        after_edge();
        chk_all("sub_4_2", 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        after_edge();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- Registered WIDTH-bit arithmetic/logic unit.
- Takes operands A and B plus a 3-bit opcode. Produces a result and status flags one clock after the operation is accepted.
- Used as the datapath execute stage of the calculator design. Upstream logic drives operands with a valid strobe; downstream logic samples result on out_valid.

Parameters:
- WIDTH, 4, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies A, B and opcode for one cycle.
- A  input  WIDTH  operand A (unsigned; two's complement for overflow flag).
- B  input  WIDTH  operand B.
- opcode  input  3  operation select.
- result  output  WIDTH  registered operation result.
- out_valid  output  1  one-cycle pulse: result and flags updated.
- carry  output  1  add carry-out / subtract borrow.
- zero  output  1  result equals 0.
- overflow  output  1  signed overflow for add/sub.
- illegal  output  1  opcode not supported in current build.

Behaviour:
- Reset: rst_n low asynchronously clears result, out_valid, carry, zero, overflow and illegal to 0. Outputs stay 0 until the first accepted operation after rst_n rises.
- Accept: on a rising clk edge with in_valid=1, the operation is computed and all outputs register on that edge. Latency is 1 cycle.
- out_valid is 1 for exactly the cycle following each accepted edge.
- Back-to-back: in_valid high on consecutive cycles yields one result per cycle, and out_valid stays high.
- in_valid=0: result and flags hold their last values; out_valid=0.
- Opcodes:
  - 000 ADD: result = (A+B) mod 2^WIDTH; carry = bit WIDTH of the full sum.
  - 001 SUB: result = (A-B) mod 2^WIDTH; carry = 1 when A<B unsigned (borrow).
  - 010 AND: A & B.
  - 011 OR: A | B.
  - 100 NOT: ~A. B is ignored.
  - 101, 110, 111: see Optional Feature.
- overflow:
  - ADD: operands have equal sign bits and the result sign differs.
  - SUB: operand sign bits differ and the result sign differs from A.
  - All other ops: 0.
- carry is 0 for all non-ADD/SUB ops.
- zero = (result == 0) for every accepted op, including illegal ones.
- illegal = 1 only for unsupported opcodes; otherwise 0.
- Reset asserted mid-stream discards any in-flight operation. No out_valid pulse is produced for it.
- No X propagation: every opcode value yields a defined result.

Optional Feature:
- Macro ALU_EXT_OPS_EN.
- Defined:
  - 101 XOR: A ^ B.
  - 110 SHL: A << B[1:0], zero fill; carry = last bit shifted out, 0 when shift amount is 0.
  - 111 SHR: logical A >> B[1:0], zero fill; carry = last bit shifted out, 0 when shift amount is 0.
  - illegal = 0 for all opcodes.
- Undefined: opcodes 101-111 yield result=0, zero=1, carry=0, overflow=0, illegal=1, with out_valid still pulsed.

Test Plan:
- Hold rst_n=0 for 100 ns, then release with in_valid=0 -> all outputs 0, out_valid never pulses.
- WIDTH=4: A=3, B=5, op=000 -> result=8, carry=0, overflow=1, zero=0. Then A=10, B=3, op=001 -> result=7, carry=0.
- A=12, B=6, op=010 -> result=4. Then A=9, B=5, op=011 -> result=13. Then A=9, op=100 -> result=6. Issued back-to-back, out_valid is high on three consecutive cycles.
- Boundaries: A=15, B=1, op=000 -> result=0, carry=1, zero=1, overflow=0. A=3, B=5, op=001 -> result=14, carry=1. A=8, B=1, op=001 -> result=7, overflow=1.
- op=101, A=9, B=5: with ALU_EXT_OPS_EN -> result=12, illegal=0; without -> result=0, illegal=1, zero=1.
- Assert rst_n low mid-stream, asynchronously between clock edges -> outputs clear immediately; no out_valid for the interrupted operation.
